// File: rtl/led_seq_pkg.sv
// Shared encodings and widths for the LED pattern sequencer.
package led_seq_pkg;

    localparam int NB_MODE = 2;
    localparam int NB_RATE = 2;

    typedef enum logic [NB_MODE-1:0] {
        MODE_ROT_L    = 2'd0,
        MODE_ROT_R    = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_FLASH    = 2'd3
    } mode_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: counts clocks against one of four limits and emits a tick.
// With STEP_INPUT_EN defined, a rising edge on i_step ticks once while disabled.
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int          NB_COUNTER = 32,
    parameter int unsigned LIMIT_0    = 2**19,
    parameter int unsigned LIMIT_1    = 2**20,
    parameter int unsigned LIMIT_2    = 2**21,
    parameter int unsigned LIMIT_3    = 2**22
)
(
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_RATE-1:0] i_rate,
`ifdef STEP_INPUT_EN
    input  logic               i_step,
`endif
    output logic               o_tick_next,
    output logic               o_tick
);

    logic [NB_COUNTER-1:0] count_q;
    logic [NB_COUNTER-1:0] count_d;
    logic [NB_COUNTER-1:0] lastCount;
    logic                  tick_q;
    logic                  tick_d;
`ifdef STEP_INPUT_EN
    logic                  step_q;
`endif

    always_comb begin
        case (i_rate)
            2'd0:    lastCount = NB_COUNTER'(LIMIT_0 - 1);
            2'd1:    lastCount = NB_COUNTER'(LIMIT_1 - 1);
            2'd2:    lastCount = NB_COUNTER'(LIMIT_2 - 1);
            default: lastCount = NB_COUNTER'(LIMIT_3 - 1);
        endcase
    end

    // A >= compare lets a switch to a shorter period tick at once instead of wrapping.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (i_enable) begin
            if (count_q >= lastCount) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + NB_COUNTER'(1);
            end
        end
`ifdef STEP_INPUT_EN
        else if (i_step && !step_q) begin
            tick_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

`ifdef STEP_INPUT_EN
    always_ff @(posedge clock) begin
        if (i_reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= i_step;
        end
    end
`endif

    assign o_tick_next = tick_d;
    assign o_tick      = tick_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mode-request FSM plus pattern stepping on prescaler ticks.
// Optional STEP_INPUT_EN adds a manual i_step input used while the prescaler is disabled.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int          NB_LEDS    = 4,
    parameter int          NB_COUNTER = 32,
    parameter int unsigned LIMIT_0    = 2**19,
    parameter int unsigned LIMIT_1    = 2**20,
    parameter int unsigned LIMIT_2    = 2**21,
    parameter int unsigned LIMIT_3    = 2**22
)
(
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_RATE-1:0] i_rate,
    input  logic [NB_MODE-1:0] i_mode,
    input  logic               i_mode_valid,
`ifdef STEP_INPUT_EN
    input  logic               i_step,
`endif
    output logic               o_mode_ready,
    output logic               o_mode_ack,
    output logic [NB_MODE-1:0] o_mode,
    output logic               o_tick,
    output logic [NB_LEDS-1:0] o_led
);

    localparam logic [NB_LEDS-1:0] SEED_LOW  = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] SEED_HIGH = {1'b1, {(NB_LEDS-1){1'b0}}};

    state_e               state_q;
    mode_e                mode_q;
    mode_e                pend_q;
    mode_e                loadMode;
    logic [NB_LEDS-1:0]   led_q;
    logic [NB_LEDS-1:0]   stepLed_d;
    logic [NB_LEDS-1:0]   loadSeed;
    logic                 dirUp_q;
    logic                 stepDir_d;
    logic                 ack_q;
    logic                 ready_q;
    logic                 tickNext;

    led_seq_prescaler #(
        .NB_COUNTER (NB_COUNTER),
        .LIMIT_0    (LIMIT_0),
        .LIMIT_1    (LIMIT_1),
        .LIMIT_2    (LIMIT_2),
        .LIMIT_3    (LIMIT_3)
    ) u_prescaler (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_rate      (i_rate),
`ifdef STEP_INPUT_EN
        .i_step      (i_step),
`endif
        .o_tick_next (tickNext),
        .o_tick      (o_tick)
    );

    always_comb begin
        stepLed_d = led_q;
        stepDir_d = dirUp_q;
        case (mode_q)
            MODE_ROT_L: stepLed_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
            MODE_ROT_R: stepLed_d = {led_q[0], led_q[NB_LEDS-1:1]};
            MODE_PINGPONG: begin
                // Turn around at either end without dwelling on the end position.
                if (dirUp_q) begin
                    if (led_q[NB_LEDS-1]) begin
                        stepLed_d = led_q >> 1;
                        stepDir_d = 1'b0;
                    end else begin
                        stepLed_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        stepLed_d = led_q << 1;
                        stepDir_d = 1'b1;
                    end else begin
                        stepLed_d = led_q >> 1;
                    end
                end
            end
            MODE_FLASH: stepLed_d = ~led_q;
            default: stepLed_d = led_q;
        endcase
    end

    // A request arriving on the loading tick wins over the one already pending.
    assign loadMode = i_mode_valid ? mode_e'(i_mode) : pend_q;
    assign loadSeed = (loadMode == MODE_ROT_R) ? SEED_HIGH : SEED_LOW;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= S_RUN;
            mode_q  <= MODE_ROT_L;
            pend_q  <= MODE_ROT_L;
            led_q   <= SEED_LOW;
            dirUp_q <= 1'b1;
            ack_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ack_q   <= 1'b0;
            ready_q <= 1'b1;
            case (state_q)
                S_RUN: begin
                    if (tickNext) begin
                        led_q   <= stepLed_d;
                        dirUp_q <= stepDir_d;
                    end
                    if (i_mode_valid) begin
                        pend_q  <= mode_e'(i_mode);
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (i_mode_valid) begin
                        pend_q <= mode_e'(i_mode);
                    end
                    if (tickNext) begin
                        mode_q  <= loadMode;
                        led_q   <= loadSeed;
                        dirUp_q <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign o_mode_ready = ready_q;
    assign o_mode_ack   = ack_q;
    assign o_mode       = mode_q;
    assign o_led        = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with short prescaler limits (4/8/16/32).
// Exercises the STEP_INPUT_EN path when that macro is defined.
module tb_led_seq_ctrl;

    localparam int NB_LEDS = 4;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_enable;
    logic [1:0]         i_rate;
    logic [1:0]         i_mode;
    logic               i_mode_valid;
    logic               i_step;
    logic               o_mode_ready;
    logic               o_mode_ack;
    logic [1:0]         o_mode;
    logic               o_tick;
    logic [NB_LEDS-1:0] o_led;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    // Reference state: prescaler count, active mode, steps taken since the last seed.
    int mCount;
    int mMode;
    int mK;
    bit mPend;
    int mPendMode;
    bit mTick;
    bit mAck;
    bit mPrevStep;

    always #5 clock = ~clock;

    led_seq_ctrl #(
        .NB_LEDS    (NB_LEDS),
        .NB_COUNTER (32),
        .LIMIT_0    (4),
        .LIMIT_1    (8),
        .LIMIT_2    (16),
        .LIMIT_3    (32)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_rate       (i_rate),
        .i_mode       (i_mode),
        .i_mode_valid (i_mode_valid),
`ifdef STEP_INPUT_EN
        .i_step       (i_step),
`endif
        .o_mode_ready (o_mode_ready),
        .o_mode_ack   (o_mode_ack),
        .o_mode       (o_mode),
        .o_tick       (o_tick),
        .o_led        (o_led)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] rate,
                                 input logic valid, input logic [1:0] mode);
        i_reset      = rst;
        i_enable     = en;
        i_rate       = rate;
        i_mode_valid = valid;
        i_mode       = mode;
        @(negedge clock);
    endtask

    task automatic waitTick();
        int n;
        n = 0;
        i_mode_valid = 1'b0;
        do begin
            @(negedge clock);
            n++;
        end while (!o_tick && n < 200);
        checkOutput("tick_seen", {31'd0, o_tick}, 32'd1);
    endtask

    function automatic int limitOf(input int rate);
        return 4 << rate;
    endfunction

    // Pattern as a pure function of the mode and the number of steps since seeding.
    function automatic logic [NB_LEDS-1:0] expectedLed(input int mode, input int k);
        logic [NB_LEDS-1:0] one;
        logic [NB_LEDS-1:0] top;
        int p;
        one = 1;
        top = one << (NB_LEDS - 1);
        case (mode)
            0: return one << (k % NB_LEDS);
            1: return top >> (k % NB_LEDS);
            2: begin
                p = k % (2 * NB_LEDS - 2);
                if (p >= NB_LEDS) p = 2 * NB_LEDS - 2 - p;
                return one << p;
            end
            default: return ((k % 2) == 1) ? ~one : one;
        endcase
    endfunction

    always @(posedge clock) begin
        bit tickNow;
        if (i_reset) begin
            mCount    = 0;
            mMode     = 0;
            mK        = 0;
            mPend     = 1'b0;
            mPendMode = 0;
            mTick     = 1'b0;
            mAck      = 1'b0;
            mPrevStep = 1'b0;
        end else begin
            tickNow = 1'b0;
            if (i_enable) begin
                if (mCount >= limitOf(int'(i_rate)) - 1) begin
                    mCount  = 0;
                    tickNow = 1'b1;
                end else begin
                    mCount++;
                end
            end
`ifdef STEP_INPUT_EN
            if (!i_enable && i_step && !mPrevStep) tickNow = 1'b1;
            mPrevStep = i_step;
`endif
            mAck = 1'b0;
            if (mPend) begin
                if (i_mode_valid) mPendMode = int'(i_mode);
                if (tickNow) begin
                    mMode = mPendMode;
                    mK    = 0;
                    mAck  = 1'b1;
                    mPend = 1'b0;
                end
            end else begin
                if (tickNow) mK++;
                if (i_mode_valid) begin
                    mPend     = 1'b1;
                    mPendMode = int'(i_mode);
                end
            end
            mTick = tickNow;
        end
        #1;
        if (checkEn) begin
            checkOutput("model_tick",  {31'd0, o_tick},       {31'd0, mTick});
            checkOutput("model_ack",   {31'd0, o_mode_ack},   {31'd0, mAck});
            checkOutput("model_ready", {31'd0, o_mode_ready}, 32'd1);
            checkOutput("model_mode",  {30'd0, o_mode},       mMode);
            checkOutput("model_led",   {28'd0, o_led},        {28'd0, expectedLed(mMode, mK)});
        end
    end

    initial begin
        logic [NB_LEDS-1:0] ppSeq [6];
        int stepTicks;
        ppSeq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

        i_reset = 1'b1; i_enable = 1'b0; i_rate = 2'd0; i_mode = 2'd0;
        i_mode_valid = 1'b0; i_step = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkEn = 1'b1;
        checkOutput("reset_led",   {28'd0, o_led},        32'h1);
        checkOutput("reset_mode",  {30'd0, o_mode},       32'd0);
        checkOutput("reset_tick",  {31'd0, o_tick},       32'd0);
        checkOutput("reset_ack",   {31'd0, o_mode_ack},   32'd0);
        checkOutput("reset_ready", {31'd0, o_mode_ready}, 32'd1);

        $display("[TB] free-running ROT_L at rate 0");
        repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s1_no_tick_yet", {31'd0, o_tick}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s1_first_tick", {31'd0, o_tick}, 32'd1);
        checkOutput("s1_led_0010", {28'd0, o_led}, 32'h2);
        waitTick(); checkOutput("s1_led_0100", {28'd0, o_led}, 32'h4);
        waitTick(); checkOutput("s1_led_1000", {28'd0, o_led}, 32'h8);
        waitTick(); checkOutput("s1_led_0001", {28'd0, o_led}, 32'h1);

        $display("[TB] switch to PINGPONG");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 2'd2);
        waitTick();
        checkOutput("s2_ack",  {31'd0, o_mode_ack}, 32'd1);
        checkOutput("s2_mode", {30'd0, o_mode}, 32'd2);
        checkOutput("s2_seed", {28'd0, o_led}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            waitTick();
            checkOutput("s2_pingpong", {28'd0, o_led}, {28'd0, ppSeq[i]});
        end

        $display("[TB] back-to-back requests, last wins");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 2'd1);
        waitTick();
        checkOutput("s3_ack",  {31'd0, o_mode_ack}, 32'd1);
        checkOutput("s3_mode", {30'd0, o_mode}, 32'd1);
        checkOutput("s3_seed", {28'd0, o_led}, 32'h8);
        waitTick();
        checkOutput("s3_no_second_ack", {31'd0, o_mode_ack}, 32'd0);
        checkOutput("s3_led_0100", {28'd0, o_led}, 32'h4);

        $display("[TB] rate drop below current count");
        repeat (20) applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        checkOutput("s4_slow_no_tick", {31'd0, o_tick}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s4_immediate_tick", {31'd0, o_tick}, 32'd1);
        checkOutput("s4_led_0010", {28'd0, o_led}, 32'h2);
        repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s4_gap", {31'd0, o_tick}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s4_period4_tick", {31'd0, o_tick}, 32'd1);
        checkOutput("s4_led_0001", {28'd0, o_led}, 32'h1);

        $display("[TB] request held while disabled");
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        repeat (100) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        checkOutput("s5_led_held", {28'd0, o_led}, 32'h1);
        checkOutput("s5_mode_held", {30'd0, o_mode}, 32'd1);
        i_enable = 1'b1;
        waitTick();
        checkOutput("s5_ack", {31'd0, o_mode_ack}, 32'd1);
        checkOutput("s5_mode", {30'd0, o_mode}, 32'd3);
        waitTick();
        checkOutput("s5_flash", {28'd0, o_led}, 32'hE);

        $display("[TB] reset while pending");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        checkOutput("s6_led", {28'd0, o_led}, 32'h1);
        checkOutput("s6_mode", {30'd0, o_mode}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        waitTick();
        checkOutput("s6_no_ack", {31'd0, o_mode_ack}, 32'd0);
        checkOutput("s6_led_step", {28'd0, o_led}, 32'h2);

`ifdef STEP_INPUT_EN
        $display("[TB] manual step pulses");
        stepTicks = 0;
        for (int p = 0; p < 3; p++) begin
            i_step = 1'b1;
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            if (o_tick) stepTicks++;
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            if (o_tick) stepTicks++;
            i_step = 1'b0;
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            if (o_tick) stepTicks++;
        end
        checkOutput("step_tick_count", stepTicks, 32'd3);
`else
        stepTicks = 0;
`endif

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            i_step = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) != 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
